// File: rtl/sram_host_port.sv
// sram_host_port
//   Bridges a request/grant host port to a single-port SRAM that has a
//   registered read (data valid one cycle after the request). Every grant
//   produces exactly one response, in grant order. Responses go through a
//   2-entry FIFO, so the host can stall with host_rready_i=0. A credit check
//   limits outstanding work (FIFO entries plus the access in flight) to two.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   host_req_i / host_gnt_o       request valid / accepted this cycle
//   host_we_i, host_addr_i        write flag, word address
//   host_be_i, host_wdata_i       byte enables, write data
//   host_rvalid_o / host_rready_i response handshake
//   host_rdata_o                  response data (read data, or 0 for writes)
//   sram_req_o, sram_write_o      SRAM request / write strobe
//   sram_addr_o, sram_wdata_o     SRAM address / write data
//   sram_wmask_o                  SRAM per-bit write mask
//   sram_rdata_i                  SRAM read data, one cycle after the request
//
// Configuration
//   SRAM_HOST_BYTE_MASK_EN  when defined, each bit of sram_wmask_o follows the
//                           byte enable of its byte. Otherwise the mask is all
//                           ones and host_be_i is ignored.

module sram_host_port #(
  parameter int Width = 32,
  parameter int Depth = 1 << 15,
  localparam int Aw         = $clog2(Depth),
  localparam int WidthBytes = Width >> 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  host_req_i,
  output logic                  host_gnt_o,
  input  logic                  host_we_i,
  input  logic [Aw-1:0]         host_addr_i,
  input  logic [WidthBytes-1:0] host_be_i,
  input  logic [Width-1:0]      host_wdata_i,
  output logic                  host_rvalid_o,
  input  logic                  host_rready_i,
  output logic [Width-1:0]      host_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_write_o,
  output logic [Aw-1:0]         sram_addr_o,
  output logic [Width-1:0]      sram_wdata_o,
  output logic [Width-1:0]      sram_wmask_o,
  input  logic [Width-1:0]      sram_rdata_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  fifo_state_e      fifo_state;
  logic [Width-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             inflight;
  logic             inflight_we;

  logic             pop;
  logic             push;
  logic [Width-1:0] push_data;
  logic [1:0]       fifo_count;
  logic [2:0]       credit_used;

  assign pop        = host_rvalid_o && host_rready_i;
  assign push       = inflight;
  // Writes still return a response so the host sees one response per grant.
  assign push_data  = inflight_we ? '0 : sram_rdata_i;
  assign fifo_count = fifo_state;

  // Entries already queued plus the access still in flight must leave room
  // for the new one; an entry leaving this cycle frees its slot immediately.
  // pop implies fifo_count >= 1, so the subtraction cannot wrap.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign host_gnt_o  = host_req_i && !rst_i && (credit_used < 3'd2);

  assign sram_req_o   = host_gnt_o;
  assign sram_write_o = host_we_i;
  assign sram_addr_o  = host_addr_i;
  assign sram_wdata_o = host_wdata_i;

`ifdef SRAM_HOST_BYTE_MASK_EN
  for (genvar i = 0; i < Width; i++) begin : g_wmask
    assign sram_wmask_o[i] = host_be_i[i/8];
  end
`else
  logic unused_be;
  assign unused_be    = ^host_be_i;
  assign sram_wmask_o = '1;
`endif

  // host_rdata_o is a dedicated register that tracks the FIFO head, so the
  // response data never has a combinational path from sram_rdata_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_state    <= EMPTY;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      inflight      <= 1'b0;
      inflight_we   <= 1'b0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
    end else begin
      inflight <= host_gnt_o;
      if (host_gnt_o) begin
        inflight_we <= host_we_i;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10: begin
          host_rvalid_o <= 1'b1;
          if (fifo_state == EMPTY) begin
            fifo_state   <= ONE;
            host_rdata_o <= push_data;
          end else begin
            fifo_state <= FULL;
          end
        end
        2'b01: begin
          if (fifo_state == FULL) begin
            fifo_state    <= ONE;
            host_rvalid_o <= 1'b1;
            host_rdata_o  <= fifo_mem[~rd_ptr];
          end else begin
            fifo_state    <= EMPTY;
            host_rvalid_o <= 1'b0;
          end
        end
        2'b11: begin
          // Count is unchanged; only the head moves.
          if (fifo_state == ONE) begin
            host_rdata_o <= push_data;
          end else begin
            host_rdata_o <= fifo_mem[~rd_ptr];
          end
        end
        default: ;
      endcase
    end
  end

  // The credit check must make an overflowing push impossible.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && fifo_state == FULL));

endmodule

// File: tb/tb_sram_host_port.sv
module tb_sram_host_port;

  localparam int Width = 32;
  localparam int Depth = 256;
  localparam int Aw    = 8;

`ifdef SRAM_HOST_BYTE_MASK_EN
  localparam logic [31:0] MergedWord = 32'h1122CCDD;
`else
  localparam logic [31:0] MergedWord = 32'hAABBCCDD;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              host_req;
  logic              host_gnt;
  logic              host_we;
  logic [Aw-1:0]     host_addr;
  logic [3:0]        host_be;
  logic [Width-1:0]  host_wdata;
  logic              host_rvalid;
  logic              host_rready;
  logic [Width-1:0]  host_rdata;
  logic              sram_req;
  logic              sram_write;
  logic [Aw-1:0]     sram_addr;
  logic [Width-1:0]  sram_wdata;
  logic [Width-1:0]  sram_wmask;
  logic [Width-1:0]  sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sram_host_port #(.Width(Width), .Depth(Depth)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .host_req_i   (host_req),
    .host_gnt_o   (host_gnt),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_be_i    (host_be),
    .host_wdata_i (host_wdata),
    .host_rvalid_o(host_rvalid),
    .host_rready_i(host_rready),
    .host_rdata_o (host_rdata),
    .sram_req_o   (sram_req),
    .sram_write_o (sram_write),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wmask_o (sram_wmask),
    .sram_rdata_i (sram_rdata)
  );

  // SRAM model: masked write, registered read.
  logic [Width-1:0] sram_mem [Depth];
  always @(posedge clk_i) begin
    if (sram_req) begin
      if (sram_write)
        sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else
        sram_rdata <= sram_mem[sram_addr];
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rready;
    logic        exp_gnt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NumVec = 21;
  vec_t vecs [NumVec];

  function automatic vec_t mk(logic req, logic we, logic [7:0] addr, logic [3:0] be,
                              logic [31:0] wdata, logic rready, logic exp_gnt,
                              logic exp_rvalid, logic [31:0] exp_rdata);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.rready = rready; v.exp_gnt = exp_gnt; v.exp_rvalid = exp_rvalid;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  function automatic logic [31:0] exp_mask(logic [3:0] be);
    logic [31:0] m;
`ifdef SRAM_HOST_BYTE_MASK_EN
    for (int b = 0; b < 32; b++) m[b] = be[b/8];
`else
    m = '1;
`endif
    return m;
  endfunction

  function automatic logic [31:0] word_val(int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010101;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic req, logic we, logic [7:0] addr, logic [3:0] be,
                       logic [31:0] wdata, logic rready);
    host_req = req; host_we = we; host_addr = addr; host_be = be;
    host_wdata = wdata; host_rready = rready;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // write/read-back, then partial write merge
    vecs[0]  = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 8'h10, 4'hF, 32'hDEADBEEF, 1, 1, 0, 32'h0);
    vecs[2]  = mk(1, 0, 8'h10, 4'h0, 32'h0,        1, 1, 0, 32'h0);
    vecs[3]  = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 1, 32'h0);
    vecs[4]  = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 1, 32'hDEADBEEF);
    vecs[5]  = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 0, 32'h0);
    vecs[6]  = mk(1, 1, 8'h04, 4'hF, 32'h11223344, 1, 1, 0, 32'h0);
    vecs[7]  = mk(1, 1, 8'h04, 4'h3, 32'hAABBCCDD, 1, 1, 0, 32'h0);
    vecs[8]  = mk(1, 0, 8'h04, 4'h0, 32'h0,        1, 1, 1, 32'h0);
    vecs[9]  = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 1, 32'h0);
    vecs[10] = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 1, MergedWord);
    vecs[11] = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 0, 32'h0);
    // stall: rready low with req held, two grants then back-pressure
    vecs[12] = mk(1, 0, 8'h10, 4'h0, 32'h0,        0, 1, 0, 32'h0);
    vecs[13] = mk(1, 0, 8'h04, 4'h0, 32'h0,        0, 1, 0, 32'h0);
    vecs[14] = mk(1, 0, 8'h10, 4'h0, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    vecs[15] = mk(1, 0, 8'h10, 4'h0, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    vecs[16] = mk(1, 0, 8'h10, 4'h0, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    vecs[17] = mk(1, 0, 8'h10, 4'h0, 32'h0,        1, 1, 1, 32'hDEADBEEF);
    vecs[18] = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 1, MergedWord);
    vecs[19] = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 1, 32'hDEADBEEF);
    vecs[20] = mk(0, 0, 8'h00, 4'h0, 32'h0,        1, 0, 0, 32'h0);

    // reset state, with a request pending
    rst_i = 1'b1;
    drive(1, 0, 8'h00, 4'h0, 32'h0, 1);
    repeat (3) next_cycle();
    @(negedge clk_i);
    check("reset gnt", 32'(host_gnt), 32'h0);
    check("reset sram_req", 32'(sram_req), 32'h0);
    check("reset rvalid", 32'(host_rvalid), 32'h0);
    check("reset rdata", host_rdata, 32'h0);
    next_cycle();
    rst_i = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].rready);
      @(negedge clk_i);
      check($sformatf("v%0d gnt", i), 32'(host_gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("v%0d sram_req", i), 32'(sram_req), 32'(vecs[i].exp_gnt));
      check($sformatf("v%0d rvalid", i), 32'(host_rvalid), 32'(vecs[i].exp_rvalid));
      if (vecs[i].exp_rvalid)
        check($sformatf("v%0d rdata", i), host_rdata, vecs[i].exp_rdata);
      if (vecs[i].req && vecs[i].we)
        check($sformatf("v%0d wmask", i), sram_wmask, exp_mask(vecs[i].be));
      next_cycle();
    end

    // back-to-back: fill addrs 0..7, then stream reads
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 8'(i), 4'hF, word_val(i), 1);
      @(negedge clk_i);
      check($sformatf("bw%0d gnt", i), 32'(host_gnt), 32'h1);
      next_cycle();
    end
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1);
    repeat (3) next_cycle();
    @(negedge clk_i);
    check("bw drained rvalid", 32'(host_rvalid), 32'h0);
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(1, 0, 8'(c), 4'h0, 32'h0, 1);
      else       drive(0, 0, 8'h00, 4'h0, 32'h0, 1);
      @(negedge clk_i);
      if (c < 8) check($sformatf("br%0d gnt", c), 32'(host_gnt), 32'h1);
      if (c >= 2) begin
        check($sformatf("br%0d rvalid", c), 32'(host_rvalid), 32'h1);
        check($sformatf("br%0d rdata", c), host_rdata, word_val(c - 2));
      end
      next_cycle();
    end
    @(negedge clk_i);
    check("br end rvalid", 32'(host_rvalid), 32'h0);
    next_cycle();

    // reset one cycle after a read grant
    drive(1, 0, 8'h03, 4'h0, 32'h0, 1);
    @(negedge clk_i);
    check("rst rd gnt", 32'(host_gnt), 32'h1);
    next_cycle();
    rst_i = 1'b1;
    drive(1, 0, 8'h06, 4'h0, 32'h0, 1);
    @(negedge clk_i);
    check("rst gnt", 32'(host_gnt), 32'h0);
    check("rst sram_req", 32'(sram_req), 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("rst2 rvalid", 32'(host_rvalid), 32'h0);
    check("rst2 rdata", host_rdata, 32'h0);
    next_cycle();
    rst_i = 1'b0;
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("post rst%0d rvalid", c), 32'(host_rvalid), 32'h0);
      check($sformatf("post rst%0d rdata", c), host_rdata, 32'h0);
      check($sformatf("post rst%0d gnt", c), 32'(host_gnt), 32'h0);
      next_cycle();
    end
    drive(1, 0, 8'h05, 4'h0, 32'h0, 1);
    @(negedge clk_i);
    check("post rst read gnt", 32'(host_gnt), 32'h1);
    next_cycle();
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1);
    @(negedge clk_i);
    check("post rst lat1 rvalid", 32'(host_rvalid), 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("post rst read rvalid", 32'(host_rvalid), 32'h1);
    check("post rst read rdata", host_rdata, word_val(5));
    next_cycle();
    @(negedge clk_i);
    check("post rst end rvalid", 32'(host_rvalid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
